// File: rtl/data_mem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// data_mem_responder : registered, wait-stated word memory behind the core's
// data port. Optional access counters and windows under DATA_MEM_STATS_EN.
// Revision: 1.0
// ============================================================================
module data_mem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH       = 64,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err
);

  localparam int          IW        = $clog2(DEPTH);
  localparam logic [32:0] BASE33    = {1'b0, BASE_ADDR};
  localparam logic [32:0] SPAN      = 33'(4 * DEPTH);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [3:0]    cnt, cnt_nxt;
  logic          access;

  logic          lat_we;
  logic [31:0]   lat_addr;
  logic [31:0]   lat_wdata;
  logic [3:0]    lat_be;
  logic          resp_err;

  logic          cur_we;
  logic [31:0]   cur_addr;
  logic [31:0]   cur_wdata;
  logic [3:0]    cur_be;

  logic [32:0]   off;
  logic          below;
  logic          in_mem;
  logic          misal;
  logic          acc_err;
  logic [IW-1:0] idx;
  logic [31:0]   read_val;

  logic [31:0]   mem [DEPTH];

  // With zero wait states the access happens on the sampling edge itself,
  // so the live inputs are used while IDLE and the latched copy afterwards.
  assign cur_we    = (state == S_IDLE) ? we    : lat_we;
  assign cur_addr  = (state == S_IDLE) ? addr  : lat_addr;
  assign cur_wdata = (state == S_IDLE) ? wdata : lat_wdata;
  assign cur_be    = (state == S_IDLE) ? be    : lat_be;

  assign off    = {1'b0, cur_addr} - BASE33;
  assign below  = ({1'b0, cur_addr} < BASE33);
  assign in_mem = !below && (off < SPAN);
  assign misal  = (cur_addr[1:0] != 2'b00);
  assign idx    = off[IW+1:2];

`ifdef DATA_MEM_STATS_EN
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;
  logic        win_rd;
  logic        win_wr;

  assign win_rd  = !below && (off == SPAN);
  assign win_wr  = !below && (off == (SPAN + 33'd4));
  assign acc_err = misal || !(in_mem || ((win_rd || win_wr) && !cur_we));

  always_comb begin
    read_val = mem[idx];
    if (win_rd) begin
      read_val = rd_cnt;
    end else if (win_wr) begin
      read_val = wr_cnt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_cnt <= 32'd0;
      wr_cnt <= 32'd0;
    end else if (access && !acc_err) begin
      if (cur_we) begin
        if (wr_cnt != 32'hFFFF_FFFF) wr_cnt <= wr_cnt + 32'd1;
      end else if (in_mem) begin
        if (rd_cnt != 32'hFFFF_FFFF) rd_cnt <= rd_cnt + 32'd1;
      end
    end
  end
`else
  assign acc_err  = misal || !in_mem;
  assign read_val = mem[idx];
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    access    = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) begin
          if (WAIT_CYCLES == 0) begin
            state_nxt = S_RESP;
            access    = 1'b1;
          end else begin
            state_nxt = S_WAIT;
            cnt_nxt   = WAIT_INIT;
          end
        end
      end
      S_WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_nxt = S_RESP;
          access    = 1'b1;
        end
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      lat_we    <= 1'b0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
      lat_be    <= 4'd0;
      rdata     <= 32'd0;
      resp_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == S_IDLE && req) begin
        lat_we    <= we;
        lat_addr  <= addr;
        lat_wdata <= wdata;
        lat_be    <= be;
      end
      if (access) begin
        resp_err <= acc_err;
        rdata    <= (acc_err || cur_we) ? 32'd0 : read_val;
      end
    end
  end

  // Array is intentionally not reset; the FSM being forced to IDLE blocks writes.
  always_ff @(posedge clk) begin
    if (access && cur_we && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (cur_be[i]) mem[idx][8*i +: 8] <= cur_wdata[8*i +: 8];
      end
    end
  end

  assign ready = (state == S_RESP);
  assign err   = ready && resp_err;

endmodule
`default_nettype wire

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Bus-side responder for the core's data-memory port. It replaces the zero-latency combinational data memory with a registered, wait-stated word memory.
- The core acts as initiator: it drives req/we/addr/wdata/be. This block answers with a one-cycle ready pulse carrying rdata or an err flag.
- It sits between the core's data port and the top-level, and lets us exercise stall handling in the core before real memories arrive.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of word 0.
- DEPTH, 64, number of 32-bit words; must be a power of 2, at least 2.
- WAIT_CYCLES, 2, extra wait-state cycles inserted before ready; range 0..15.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- req  input  1  initiator requests a transaction; sampled only in IDLE
- we  input  1  1 = write, 0 = read
- addr  input  32  byte address
- wdata  input  32  write data
- be  input  4  byte enables; be[i] covers wdata[8i+7:8i]
- rdata  output  32  read data; valid only while ready=1
- ready  output  1  one-cycle completion pulse
- err  output  1  error flag; valid only while ready=1

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, ready=0, err=0, rdata=0, wait counter=0.
  - Memory array is not cleared.
  - Reset mid-transaction aborts it; a pending write is discarded.
- FSM states: IDLE, WAIT, RESP.
- IDLE, on a rising edge with req=1:
  - Latch we, addr, wdata, be.
  - Decode and range-check addr.
  - If WAIT_CYCLES=0, go to RESP; else go to WAIT with counter=WAIT_CYCLES.
- WAIT: counter decrements every cycle. When counter=1, the next edge performs the access and enters RESP.
- Access, on the edge entering RESP:
  - Read: rdata <= mem[index].
  - Write: mem[index] byte i <= wdata byte i for each be[i]=1. rdata <= 0.
  - be=4'b0000 on a write is a legal no-op.
  - Reads ignore be.
- RESP: ready=1 for exactly one cycle, then IDLE unconditionally.
- Latency: ready is high during cycle WAIT_CYCLES+1 after the edge that sampled req.
- Throughput: one transaction per WAIT_CYCLES+2 cycles.
- req/we/addr/wdata/be are don't-care outside IDLE; latched values are used.
- req still high in the IDLE cycle after RESP starts a new transaction. The initiator drops req in the ready cycle unless it issues back-to-back.
- index = (addr - BASE_ADDR) >> 2.
- Error conditions:
  - addr < BASE_ADDR, or addr >= BASE_ADDR + 4*DEPTH (compute with 33-bit arithmetic, no wrap).
  - addr[1:0] != 0.
- On error: no memory update, rdata=0, err=1 together with ready. Timing is identical to a normal access.
- err=0 whenever ready=0.
- Read-after-write to the same word in back-to-back transactions returns the new data.

Optional Feature:
- Macro: DATA_MEM_STATS_EN.
- Defined:
  - Two 32-bit saturating counters, rd_cnt and wr_cnt.
  - They count successful (err=0) reads and writes on the access edge. Error accesses are not counted.
  - Both reset to 0.
  - Read-only windows:
    - BASE_ADDR + 4*DEPTH returns rd_cnt as the value before the current read.
    - BASE_ADDR + 4*DEPTH + 4 returns wr_cnt.
  - Reads of these windows complete with err=0 and do not count themselves.
  - Writes to these windows give err=1.
  - Any address beyond the windows gives err=1.
- Not defined: no counters; those two addresses are out of range and give err=1.

Test Plan:
- Reset with defaults, then write addr=0x10 wdata=0xDEADBEEF be=4'hF, then read 0x10 -> ready high 3 cycles after the req edge, rdata=0xDEADBEEF, err=0.
- Write 0x10 wdata=0x11223344 be=4'b0101 over 0xDEADBEEF -> next read of 0x10 returns 0xDE22BE44.
- Reads of addr=0x102 and addr=0x100 (DEPTH=64) -> each gives ready with err=1 and rdata=0. A subsequent read of 0x10 returns unchanged data.
- WAIT_CYCLES=0 with req held high for 3 back-to-back reads -> ready pulses exactly every 2nd cycle, with err=0 on each.
- Drive reset=0 asynchronously mid-WAIT of a write to 0x20 -> ready and err drop immediately. A later read of 0x20 returns the pre-write value.
- With DATA_MEM_STATS_EN: 3 writes, 2 reads, 1 error, then read 0x100 -> 2 and read 0x104 -> 3. A write to 0x100 gives err=1.
